// File: rtl/snoop_arbiter.sv
// Two-requester round-robin arbiter for the CPU snoop port. Each requester has its
// own auto-incrementing address pointer. One transaction is in flight at a time.
module snoop_arbiter #(
  parameter int READ_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [1:0] op0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic [1:0] op1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic [7:0] rdata,
  output logic       busy,
  output logic [7:0] snoopa,
  output logic [7:0] snoopd,
  input  logic [7:0] snoopq,
  output logic       snoopp,
  output logic       snoopm
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT, ACK} state_t;

  localparam logic [2:0] LAT_INIT   = 3'(READ_LAT);
  localparam logic [1:0] OP_SETADDR = 2'b00;
  localparam logic [1:0] OP_PROG    = 2'b01;
  localparam logic [1:0] OP_READ    = 2'b10;
  localparam logic [1:0] OP_MEMW    = 2'b11;

  state_t     state_reg, state_next;
  logic       gnt_reg, gnt_next;
  logic       last_grant_reg, last_grant_next;
  logic [1:0] op_reg, op_next;
  logic [7:0] data_reg, data_next;
  logic [2:0] cnt_reg, cnt_next;
  logic [7:0] snoopa_reg, snoopa_next;
  logic [7:0] snoopd_reg, snoopd_next;
  logic [7:0] rdata_reg, rdata_next;
  logic [15:0] addr_flat;
  logic [1:0] ack_vec;

  logic       grant_sel;
  logic [1:0] op_sel;
  logic [7:0] data_sel;
  logic [7:0] addr_sel;

  // On a tie the requester that did not win last time gets the port.
  assign grant_sel = (req0 && req1) ? ~last_grant_reg : req1;
  assign op_sel    = grant_sel ? op1 : op0;
  assign data_sel  = grant_sel ? data1 : data0;
  assign addr_sel  = grant_sel ? addr_flat[15:8] : addr_flat[7:0];

  always_comb begin
    state_next      = state_reg;
    gnt_next        = gnt_reg;
    last_grant_next = last_grant_reg;
    op_next         = op_reg;
    data_next       = data_reg;
    cnt_next        = cnt_reg;
    snoopa_next     = snoopa_reg;
    snoopd_next     = snoopd_reg;
    rdata_next      = rdata_reg;
    case (state_reg)
      IDLE: begin
        if (req0 || req1) begin
          gnt_next        = grant_sel;
          last_grant_next = grant_sel;
          op_next         = op_sel;
          data_next       = data_sel;
          if (op_sel == OP_SETADDR) begin
            state_next = ACK;
          end else begin
            snoopa_next = addr_sel;
            snoopd_next = data_sel;
            state_next  = SETUP;
          end
        end
      end
      SETUP: begin
        if (op_reg == OP_READ) begin
          cnt_next   = LAT_INIT;
          state_next = WAIT;
        end else begin
          state_next = STROBE;
        end
      end
      STROBE: state_next = ACK;
      WAIT: begin
        if (cnt_reg == 3'd1) begin
          rdata_next = snoopq;
          state_next = ACK;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      gnt_reg        <= 1'b0;
      last_grant_reg <= 1'b1;
      op_reg         <= OP_SETADDR;
      data_reg       <= 8'h00;
      cnt_reg        <= 3'd0;
      snoopa_reg     <= 8'h00;
      snoopd_reg     <= 8'h00;
      rdata_reg      <= 8'h00;
    end else begin
      state_reg      <= state_next;
      gnt_reg        <= gnt_next;
      last_grant_reg <= last_grant_next;
      op_reg         <= op_next;
      data_reg       <= data_next;
      cnt_reg        <= cnt_next;
      snoopa_reg     <= snoopa_next;
      snoopd_reg     <= snoopd_next;
      rdata_reg      <= rdata_next;
    end
  end

  // Per-requester pointer and ack; only the granted requester's pointer moves.
  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    logic [7:0] addr_reg;
    always_ff @(posedge clk) begin
      if (reset) begin
        addr_reg <= 8'h00;
      end else if (state_reg == ACK && gnt_reg == 1'(gi)) begin
        addr_reg <= (op_reg == OP_SETADDR) ? data_reg : addr_reg + 8'd1;
      end
    end
    assign addr_flat[gi*8 +: 8] = addr_reg;
    assign ack_vec[gi] = (state_reg == ACK) && (gnt_reg == 1'(gi));
  end

  assign ack0   = ack_vec[0];
  assign ack1   = ack_vec[1];
  assign busy   = (state_reg != IDLE);
  assign snoopa = snoopa_reg;
  assign snoopd = snoopd_reg;
  assign rdata  = rdata_reg;
  assign snoopp = (state_reg == STROBE) && (op_reg == OP_PROG);
  assign snoopm = (state_reg == STROBE) && (op_reg == OP_MEMW);

endmodule
